alu_flag_unit: RTL and testbench
================================

ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (>=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, overflow event counter width (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation record valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a record.
REQ-007 SHALL have ports num1, num2, result  input  WIDTH  operands and ALU result.
REQ-008 SHALL have port carry_in  input  1  adder carry-out.
REQ-009 SHALL have port control  input  2  op code: 00 add, 01 sub, 1x non-arithmetic.
REQ-010 SHALL have port out_valid  output  1  flag set valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts flags.
REQ-012 SHALL have ports flag_n, flag_z, flag_c, flag_v  output  1 each  registered NZCV.
REQ-013 SHALL have port sticky_clr  input  1  clears sticky_v and ovf_count.
REQ-014 SHALL have ports sticky_v  output  1 and ovf_count  output  CNT_WIDTH  accumulated overflow status.

Function
REQ-015 SHALL accept a record when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-016 SHALL present flags of an accepted record with exactly one cycle latency, out_valid high the next cycle.
REQ-017 SHALL hold flags and out_valid stable while out_valid && !out_ready; out_valid drops after out_ready handshake unless a new record is accepted same cycle.
REQ-018 SHALL compute N = result[WIDTH-1]; Z = (result == 0).
REQ-019 SHALL compute V = !control[1] & (num1[MSB] ^ result[MSB]) & !(num1[MSB] ^ num2[MSB] ^ control[0]).
REQ-020 SHALL compute C = carry_in when control[1]==0, else 0.
REQ-021 SHALL, per accepted record with V=1, set sticky_v and increment ovf_count, saturating at all-ones (no wrap).
REQ-022 SHALL, on sticky_clr, clear sticky_v and ovf_count; if an accepted V=1 record coincides, sticky_v=1 and ovf_count=1 (set wins).
REQ-023 SHALL update sticky state on acceptance, independent of out_ready.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, flag_n/z/c/v=0, sticky_v=0, ovf_count=0 immediately (asynchronous).
REQ-025 SHALL discard any held record on reset mid-transfer; in_ready=1 first cycle after release.

Configuration
REQ-026 SHALL compile sticky tracking (REQ-021..023) only when ALU_FLAGS_STICKY_EN is defined.
REQ-027 SHALL, without ALU_FLAGS_STICKY_EN, tie sticky_v=0, ovf_count=0 and ignore sticky_clr; NZCV path unchanged.

Structure
REQ-028 SHALL place control encodings (CTRL_ADD=2'b00, CTRL_SUB=2'b01) and a packed NZCV flags struct typedef in package alu_flags_pkg.
REQ-029 SHALL isolate combinational NZCV derivation in one sub-module alu_flag_calc (parametrised WIDTH); registers, handshake and sticky logic in alu_flag_unit.

Verification (WIDTH=8 unless stated)
REQ-030 SHALL cover add 0x7F+0x01, result 0x80, carry_in 0, control 00 -> next cycle N=1 Z=0 C=0 V=1, sticky_v=1, ovf_count=1.
REQ-031 SHALL cover sub 0x80-0x01, result 0x7F, carry_in 1, control 01 -> V=1 N=0 C=1; then 0x05-0x05 result 0x00 -> Z=1 V=0.
REQ-032 SHALL cover AND 0x0F,0xF0 result 0x00 control 10 carry_in 1 -> Z=1 C=0 V=0, ovf_count unchanged.
REQ-033 SHALL cover out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, flags held; out_ready=1 -> next record accepted same cycle.
REQ-034 SHALL cover CNT_WIDTH=2, five overflowing adds -> ovf_count=3; sticky_clr with sixth overflow -> ovf_count=1, sticky_v=1.
REQ-035 SHALL cover rst_n low mid-backpressure -> out_valid, flags, sticky state 0 without clock edge; build without ALU_FLAGS_STICKY_EN -> sticky_v, ovf_count stay 0.

Source files
------------

// File: rtl/alu_flags_pkg.sv
// Shared encodings and the NZCV flag bundle for the ALU flag unit.
// Imported by alu_flag_calc and alu_flag_unit.
package alu_flags_pkg;

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational NZCV derivation from operands, result and adder carry.
// Purely combinational; registered by alu_flag_unit.
module alu_flag_calc
  import alu_flags_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic [1:0]       control,
  output nzcv_t            flags
);

  localparam int MSB = WIDTH - 1;

  logic arith;
  logic same_sign;

  assign arith = !control[1];

  // Operand signs agree once the subtrahend is sign-flipped for SUB.
  assign same_sign = !(num1[MSB] ^ num2[MSB] ^ control[0]);

  always_comb begin
    flags   = '0;
    flags.n = result[MSB];
    flags.z = (result == '0);
    flags.c = arith & carry_in;
    flags.v = arith & (num1[MSB] ^ result[MSB]) & same_sign;
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Registered NZCV flag stage with valid/ready handshake.
// Sticky overflow tracking is built only with ALU_FLAGS_STICKY_EN.
module alu_flag_unit
  import alu_flags_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic [WIDTH-1:0]     result,
  input  logic                 carry_in,
  input  logic [1:0]           control,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  input  logic                 sticky_clr,
  output logic                 sticky_v,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  nzcv_t calc_flags;
  nzcv_t flags_d, flags_q;
  logic  out_valid_d, out_valid_q;
  logic  accept;

  alu_flag_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .num1    (num1),
    .num2    (num2),
    .result  (result),
    .carry_in(carry_in),
    .control (control),
    .flags   (calc_flags)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      flags_d     = calc_flags;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;

`ifdef ALU_FLAGS_STICKY_EN
  logic                 sticky_d, sticky_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  // A clear coinciding with a new overflow restarts the count at one.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (accept && calc_flags.v) begin
      sticky_d = 1'b1;
      if (sticky_clr) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_v  = sticky_q;
  assign ovf_count = cnt_q;
`else
  logic unused_sticky_clr;

  assign unused_sticky_clr = sticky_clr;
  assign sticky_v          = 1'b0;
  assign ovf_count         = '0;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed self-checking bench for alu_flag_unit (WIDTH=8, CNT_WIDTH=2).
// Sticky expectations follow ALU_FLAGS_STICKY_EN.
module tb_alu_flag_unit;

`ifdef ALU_FLAGS_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] num1, num2, result;
  logic       carry_in;
  logic [1:0] control;
  logic       out_valid;
  logic       out_ready;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       sticky_clr;
  logic       sticky_v;
  logic [1:0] ovf_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_flag_unit #(
    .WIDTH    (8),
    .CNT_WIDTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .result    (result),
    .carry_in  (carry_in),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .sticky_clr(sticky_clr),
    .sticky_v  (sticky_v),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input logic v, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] r,
                     input logic ci, input logic [1:0] ctl);
    in_valid = v;
    num1     = a;
    num2     = b;
    result   = r;
    carry_in = ci;
    control  = ctl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nzcv;
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  function automatic logic [2:0] stk(input logic s, input logic [1:0] c);
    return STK ? {s, c} : 3'b000;
  endfunction

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    sticky_clr = 1'b0;
    rec(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {28'd0, nzcv()}, 32'd0);
    chk("rst_sticky", {29'd0, sticky_v, ovf_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rel_ready", {31'd0, in_ready}, 32'd1);

    rec(1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b00);
    tick();
    chk("add_ovf_valid", {31'd0, out_valid}, 32'd1);
    chk("add_ovf_nzcv", {28'd0, nzcv()}, 32'b1001);
    chk("add_ovf_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 1)});

    rec(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 2'b01);
    tick();
    chk("sub_ovf_nzcv", {28'd0, nzcv()}, 32'b0011);
    chk("sub_ovf_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 2)});

    rec(1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 2'b01);
    tick();
    chk("sub_zero_nzcv", {28'd0, nzcv()}, 32'b0110);

    rec(1'b1, 8'h0F, 8'hF0, 8'h00, 1'b1, 2'b10);
    tick();
    chk("and_nzcv", {28'd0, nzcv()}, 32'b0100);
    chk("and_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 2)});

    rec(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    rec(1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b00);
    tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 3)});
    rec(1'b1, 8'h01, 8'h01, 8'h02, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_nzcv", {28'd0, nzcv()}, 32'b1001);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_nzcv", {28'd0, nzcv()}, 32'b0000);

    rec(1'b1, 8'h40, 8'h40, 8'h80, 1'b0, 2'b00);
    tick();
    rec(1'b1, 8'h7F, 8'h7F, 8'hFE, 1'b0, 2'b00);
    tick();
    chk("sat_nzcv", {28'd0, nzcv()}, 32'b1001);
    chk("sat_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 3)});

    sticky_clr = 1'b1;
    rec(1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 2'b00);
    tick();
    chk("clr_set_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 1)});
    rec(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
    tick();
    chk("clr_only_stk", {29'd0, sticky_v, ovf_count}, 32'd0);
    sticky_clr = 1'b0;

    out_ready = 1'b0;
    rec(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 2'b01);
    tick();
    chk("pre_rst_nzcv", {28'd0, nzcv()}, 32'b0011);
    chk("pre_rst_stk", {29'd0, sticky_v, ovf_count}, {29'd0, stk(1, 1)});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_nzcv", {28'd0, nzcv()}, 32'd0);
    chk("async_stk", {29'd0, sticky_v, ovf_count}, 32'd0);
    rec(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
    tick();
    rst_n = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
